tsp_core: RTL and testbench

- Self-contained travelling-salesman heuristic engine.
- After reset it generates N pseudo-random 8-bit city coordinates from an internal LFSR and starts with the identity tour.
- It then runs random-swap local search forever, keeping a swap only if it shortens the closed-tour Manhattan length.
- Exposes the coordinates, the current tour and the best length (`performance`); a top-level wrapper samples `performance` onto 7-segment digits via the separate seg7 decoder.

---
 rtl/tsp_pkg.sv | 29 ++
 rtl/tsp_lfsr.sv | 25 ++
 rtl/tsp_core.sv | 141 ++++++++++++++
 tb/tb_tsp_core.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsp_pkg.sv
// rtl/tsp_pkg.sv - shared types, defaults and distance helper for the TSP engine
package tsp_pkg;

    localparam int N_DEFAULT       = 64;
    localparam int IDX_W_DEFAULT   = 6;
    localparam int COORD_W_DEFAULT = 8;

    typedef logic [7:0] coord_t;
    typedef logic [5:0] idx_t;

    typedef enum logic [2:0] {
        INIT,
        SUM,
        PICK,
        EVAL,
        DECIDE
    } state_t;

    // Manhattan distance between two points; 9 bits holds the 510 maximum.
    function automatic logic [8:0] manhattan(input coord_t xa, input coord_t ya,
                                             input coord_t xb, input coord_t yb);
        logic [7:0] dx;
        logic [7:0] dy;
        dx = (xa > xb) ? (xa - xb) : (xb - xa);
        dy = (ya > yb) ? (ya - yb) : (yb - ya);
        return {1'b0, dx} + {1'b0, dy};
    endfunction

endpackage

// File: rtl/tsp_lfsr.sv
// rtl/tsp_lfsr.sv - 16-bit Fibonacci LFSR with enable
module tsp_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign lfsr_o = lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else if (en_i) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/tsp_core.sv
// rtl/tsp_core.sv - random-swap local search over a closed Manhattan tour
module tsp_core
    import tsp_pkg::*;
#(
    parameter int          N       = N_DEFAULT,
    parameter int          IDX_W   = IDX_W_DEFAULT,
    parameter int          COORD_W = COORD_W_DEFAULT,
    parameter int          PERF_W  = 32,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [COORD_W-1:0] xs [N],
    output logic [COORD_W-1:0] ys [N],
    output logic [IDX_W-1:0]   path [N],
    output logic [PERF_W-1:0]  performance
);

    state_t state_q;
    state_t state_d;

    logic [COORD_W-1:0] xs_q [N];
    logic [COORD_W-1:0] ys_q [N];
    logic [IDX_W-1:0]   path_q [N];
    logic [PERF_W-1:0]  perf_q;
    logic [15:0]        acc_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   a_q;
    logic [IDX_W-1:0]   b_q;

    logic [15:0]      lfsr;
    logic             lfsr_en;
    logic [IDX_W-1:0] pick_a;
    logic [IDX_W-1:0] pick_b;
    logic [IDX_W-1:0] nxt_idx;
    logic [8:0]       term;
    logic [15:0]      acc_sum;
    logic             last;

    tsp_lfsr #(.SEED(SEED)) u_lfsr (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (lfsr_en),
        .lfsr_o (lfsr)
    );

    assign pick_a  = lfsr[IDX_W-1:0];
    assign pick_b  = lfsr[2*IDX_W-1:IDX_W];
    // Counter wraps naturally, so position N-1 pairs with position 0.
    assign nxt_idx = cnt_q + IDX_W'(1);
    assign term    = manhattan(xs_q[path_q[cnt_q]], ys_q[path_q[cnt_q]],
                               xs_q[path_q[nxt_idx]], ys_q[path_q[nxt_idx]]);
    assign acc_sum = acc_q + 16'(term);
    assign last    = (cnt_q == IDX_W'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_en = 1'b0;
        case (state_q)
            INIT: begin
                lfsr_en = 1'b1;
                if (last) state_d = SUM;
            end
            SUM:    if (last) state_d = PICK;
            PICK: begin
                lfsr_en = 1'b1;
                if (pick_a != pick_b) state_d = EVAL;
            end
            EVAL:   if (last) state_d = DECIDE;
            DECIDE: state_d = PICK;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                xs_q[k]   <= '0;
                ys_q[k]   <= '0;
                path_q[k] <= IDX_W'(k);
            end
            perf_q <= '1;
            acc_q  <= '0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    xs_q[cnt_q] <= lfsr[7:0];
                    ys_q[cnt_q] <= lfsr[15:8];
                    cnt_q       <= nxt_idx;
                    acc_q       <= '0;
                end
                SUM: begin
                    acc_q <= acc_sum;
                    cnt_q <= nxt_idx;
                    if (last) perf_q <= PERF_W'(acc_sum);
                end
                PICK: begin
                    if (pick_a != pick_b) begin
                        path_q[pick_a] <= path_q[pick_b];
                        path_q[pick_b] <= path_q[pick_a];
                        a_q            <= pick_a;
                        b_q            <= pick_b;
                        acc_q          <= '0;
                        cnt_q          <= '0;
                    end
                end
                EVAL: begin
                    acc_q <= acc_sum;
                    cnt_q <= nxt_idx;
                end
                DECIDE: begin
                    // Ties are rejected so the tour only changes on strict improvement.
                    if (PERF_W'(acc_q) < perf_q) begin
                        perf_q <= PERF_W'(acc_q);
                    end else begin
                        path_q[a_q] <= path_q[b_q];
                        path_q[b_q] <= path_q[a_q];
                    end
                end
                default: ;
            endcase
        end
    end

    assign xs          = xs_q;
    assign ys          = ys_q;
    assign path        = path_q;
    assign performance = perf_q;

endmodule

// File: tb/tb_tsp_core.sv
// tb/tb_tsp_core.sv - self-checking bench for tsp_core at N=4 and N=64
module tb_tsp_core;

    localparam int NS = 4;
    localparam int IS = 2;
    localparam int NL = 64;
    localparam int IL = 6;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst_s;
    logic rst_l;

    logic [7:0]    xs_s [NS];
    logic [7:0]    ys_s [NS];
    logic [IS-1:0] path_s [NS];
    logic [31:0]   perf_s;
    logic [7:0]    xs_l [NL];
    logic [7:0]    ys_l [NL];
    logic [IL-1:0] path_l [NL];
    logic [31:0]   perf_l;

    int checks = 0;
    int errors = 0;

    int mx [NL];
    int my [NL];
    int mpath [NL];
    int mperf;
    logic [15:0] ml;

    tsp_core #(.N(NS), .IDX_W(IS), .COORD_W(8), .PERF_W(32), .SEED(SEED)) dut_s (
        .clk(clk), .rst(rst_s), .xs(xs_s), .ys(ys_s), .path(path_s), .performance(perf_s));

    tsp_core #(.N(NL), .IDX_W(IL), .COORD_W(8), .PERF_W(32), .SEED(SEED)) dut_l (
        .clk(clk), .rst(rst_l), .xs(xs_l), .ys(ys_l), .path(path_l), .performance(perf_l));

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int model_len(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) begin
            int p = mpath[i];
            int q = mpath[(i + 1) % n];
            s += iabs(mx[p] - mx[q]) + iabs(my[p] - my[q]);
        end
        return s;
    endfunction

    function automatic int dut_len_l();
        int s = 0;
        for (int i = 0; i < NL; i++) begin
            int p = int'(path_l[i]);
            int q = int'(path_l[(i + 1) % NL]);
            s += iabs(mx[p] - mx[q]) + iabs(my[p] - my[q]);
        end
        return s;
    endfunction

    task automatic model_init(input int n);
        ml = SEED;
        for (int k = 0; k < n; k++) begin
            mx[k]    = int'(ml[7:0]);
            my[k]    = int'(ml[15:8]);
            ml       = lfsr_step(ml);
            mpath[k] = k;
        end
        mperf = model_len(n);
    endtask

    // One accepted-or-rejected trial; returns cycles to DECIDE exit and cycles spent picking.
    task automatic model_iter(input int n, input int idx_w, output int cycles,
                              output int pick_cycles, output bit tie);
        int a, b, t, len;
        cycles = 0;
        tie    = 1'b0;
        do begin
            a  = int'(ml) & (n - 1);
            b  = (int'(ml) >> idx_w) & (n - 1);
            ml = lfsr_step(ml);
            cycles++;
        end while (a == b);
        pick_cycles = cycles;
        t = mpath[a]; mpath[a] = mpath[b]; mpath[b] = t;
        len = model_len(n);
        cycles += n + 1;
        if (len < mperf) begin
            mperf = len;
        end else begin
            tie = (len == mperf);
            t = mpath[a]; mpath[a] = mpath[b]; mpath[b] = t;
        end
    endtask

    task automatic tick(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic check_small_state(input string tag);
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (int'(path_s[i]) !== mpath[i]) begin
                errors++;
                $display("FAIL %s path[%0d]: got %0d expected %0d", tag, i, path_s[i], mpath[i]);
            end
        end
        checks++;
        if (perf_s !== 32'(mperf)) begin
            errors++;
            $display("FAIL %s perf: got %0d expected %0d", tag, perf_s, mperf);
        end
    endtask

    task automatic check_small_reset_values(input string tag);
        checks++;
        if (perf_s !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL %s perf: got %h expected ffffffff", tag, perf_s);
        end
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (int'(path_s[i]) !== i || xs_s[i] !== 8'h00 || ys_s[i] !== 8'h00) begin
                errors++;
                $display("FAIL %s city %0d: got path=%0d x=%h y=%h expected path=%0d x=00 y=00",
                         tag, i, path_s[i], xs_s[i], ys_s[i], i);
            end
        end
    endtask

    task automatic check_small_coords(input string tag);
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (int'(xs_s[k]) !== mx[k] || int'(ys_s[k]) !== my[k]) begin
                errors++;
                $display("FAIL %s coord %0d: got (%0d,%0d) expected (%0d,%0d)",
                         tag, k, xs_s[k], ys_s[k], mx[k], my[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_s = 1'b0;
        rst_l = 1'b0;
        tick(2);
        check_small_reset_values("reset_hold");
        checks++;
        if (perf_l !== 32'hFFFF_FFFF || path_l[NL-1] !== 6'd63) begin
            errors++;
            $display("FAIL reset_hold_large: got perf=%h path63=%0d expected ffffffff 63", perf_l, path_l[NL-1]);
        end
        @(negedge clk);
        rst_s = 1'b1;
        tick(1);
        checks++;
        if (xs_s[0] !== 8'hE1 || ys_s[0] !== 8'hAC) begin
            errors++;
            $display("FAIL first_coord: got x=%h y=%h expected x=e1 y=ac", xs_s[0], ys_s[0]);
        end
    endtask

    task automatic test_first_sum();
        model_init(NS);
        tick(2 * NS - 2);
        checks++;
        if (perf_s !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL perf_early: got %h expected ffffffff at cycle %0d", perf_s, 2 * NS - 1);
        end
        tick(1);
        check_small_coords("init_coords");
        check_small_state("first_sum");
    endtask

    task automatic test_small_search();
        int cyc, pc, ties;
        bit tie;
        int prev;
        ties = 0;
        for (int it = 0; it < 150; it++) begin
            prev = mperf;
            model_iter(NS, IS, cyc, pc, tie);
            tick(cyc);
            check_small_state("small_iter");
            if (tie) begin
                ties++;
                checks++;
                if (perf_s !== 32'(prev)) begin
                    errors++;
                    $display("FAIL tie_reject: got %0d expected %0d", perf_s, prev);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int cyc, pc;
        bit tie;
        model_iter(NS, IS, cyc, pc, tie);
        tick(pc + 2);
        #2;
        rst_s = 1'b0;
        #1;
        check_small_reset_values("async_reset");
        @(negedge clk);
        rst_s = 1'b1;
        model_init(NS);
        tick(2 * NS);
        check_small_coords("rerun_coords");
        check_small_state("rerun_sum");
    endtask

    task automatic test_large_run();
        int cyc, pc, total, perf128, dl;
        bit tie;
        logic [31:0] prev;
        bit [NL-1:0] seen;
        @(negedge clk);
        rst_l = 1'b1;
        model_init(NL);
        tick(2 * NL);
        perf128 = mperf;
        checks++;
        if (perf_l !== 32'(mperf) || path_l[5] !== 6'd5) begin
            errors++;
            $display("FAIL large_sum: got perf=%0d path5=%0d expected %0d 5", perf_l, path_l[5], mperf);
        end
        total = 2 * NL;
        prev  = perf_l;
        while (total < 40000) begin
            model_iter(NL, IL, cyc, pc, tie);
            for (int c = 0; c < cyc; c++) begin
                tick(1);
                checks++;
                if (perf_l > prev) begin
                    errors++;
                    $display("FAIL monotonic: got %0d after %0d", perf_l, prev);
                end
                prev = perf_l;
            end
            total += cyc;
            seen = '0;
            for (int i = 0; i < NL; i++) seen[path_l[i]] = 1'b1;
            checks++;
            if (seen !== {NL{1'b1}}) begin
                errors++;
                $display("FAIL permutation: got %h expected all ones", seen);
            end
            checks++;
            if (perf_l !== 32'(mperf)) begin
                errors++;
                $display("FAIL large_perf: got %0d expected %0d", perf_l, mperf);
            end
            dl = dut_len_l();
            checks++;
            if (perf_l !== 32'(dl)) begin
                errors++;
                $display("FAIL path_length: got %0d expected %0d", perf_l, dl);
            end
            for (int i = 0; i < NL; i++) begin
                checks++;
                if (int'(path_l[i]) !== mpath[i]) begin
                    errors++;
                    $display("FAIL large_path[%0d]: got %0d expected %0d", i, path_l[i], mpath[i]);
                end
            end
        end
        checks++;
        if (!(perf_l < 32'(perf128))) begin
            errors++;
            $display("FAIL improvement: got %0d expected below %0d", perf_l, perf128);
        end
    endtask

    initial begin
        test_reset();
        test_first_sum();
        test_small_search();
        test_async_reset();
        test_large_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
